// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game front end: button count, timing base
// and the per-button debounce FSM state encoding.
package simon_pkg;

    localparam int unsigned N_BTN        = 4;
    localparam int unsigned TICKS_PER_MS = 25000;

    localparam logic [1:0] BTN_ENC_IDLE         = 2'd0;
    localparam logic [1:0] BTN_ENC_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] BTN_ENC_PRESSED      = 2'd2;
    localparam logic [1:0] BTN_ENC_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE         = BTN_ENC_IDLE,
        ST_PRESS_WAIT   = BTN_ENC_PRESS_WAIT,
        ST_PRESSED      = BTN_ENC_PRESSED,
        ST_RELEASE_WAIT = BTN_ENC_RELEASE_WAIT
    } btn_state_t;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM with stability counter,
// registered debounced level and one-cycle press/release pulses.
module btn_debounce_ch
    import simon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_TICKS = 250000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit   ONE_TICK = (DEBOUNCE_TICKS == 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    btn_state_t             state;
    btn_state_t             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    // Metastability filter on the raw pin.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // A single stable tick means the wait states are skipped entirely.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    if (ONE_TICK) begin
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    if (ONE_TICK) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_WAIT);
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Debounces the game buttons and holds one pending press event for the game
// FSM behind a valid/ack handshake, flagging any press that had to be dropped.
module btn_debounce #(
    parameter  int unsigned N_BTN          = simon_pkg::N_BTN,
    parameter  int unsigned SYNC_STAGES    = 2,
    parameter  int unsigned DEBOUNCE_TICKS = 250000,
    localparam int unsigned ID_W           = simon_pkg::id_width(N_BTN)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             press_valid,
    output logic [ID_W-1:0]  press_id,
    input  logic             press_ack,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic [ID_W-1:0] lo_idx;
    logic            any_press;
    logic            multi_press;
    logic            load;
    logic            ovr_set;

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_ch (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_press[i]),
            .fall (btn_release[i])
        );
    end

    // Lowest set index wins; scanning downwards lets the lowest overwrite last.
    always_comb begin
        lo_idx = '0;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                lo_idx = ID_W'(i);
            end
        end
    end

    assign any_press   = |btn_press;
    assign multi_press = |(btn_press & (btn_press - N_BTN'(1)));
    assign load        = any_press && (!press_valid || press_ack);
    assign ovr_set     = multi_press || (any_press && press_valid && !press_ack);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            press_valid <= 1'b0;
            press_id    <= '0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                press_valid <= 1'b1;
                press_id    <= lo_idx;
            end else if (press_ack) begin
                press_valid <= 1'b0;
            end
            if (overrun_clr) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with 8-tick debounce: directed scenarios plus random
// button activity, all compared against a stability-run reference model.
module tb_btn_debounce;

    localparam int unsigned NB = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DT = 8;

    logic          CLK;
    logic          RST;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          press_valid;
    logic [1:0]    press_id;
    logic          press_ack;
    logic          overrun;
    logic          overrun_clr;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .N_BTN         (NB),
        .SYNC_STAGES   (SS),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_valid(press_valid),
        .press_id   (press_id),
        .press_ack  (press_ack),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: level flips once the synchronised input has disagreed
    // with it for DT consecutive edges; events follow the handshake rules.
    logic [NB-1:0] m_level, m_press, m_release, m_s;
    logic          m_valid, m_ovr, m_oset;
    logic [1:0]    m_id;
    int            m_run[NB];
    int            m_lo, m_nset;
    logic [NB-1:0] hist[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist.delete();
            for (int k = 0; k < int'(SS); k++) hist.push_back('0);
            for (int k = 0; k < int'(NB); k++) m_run[k] = 0;
            m_level = '0; m_press = '0; m_release = '0;
            m_valid = 1'b0; m_id = '0; m_ovr = 1'b0;
        end else begin
            m_lo = -1; m_nset = 0; m_oset = 1'b0;
            for (int k = 0; k < int'(NB); k++) begin
                if (m_press[k]) begin
                    m_nset++;
                    if (m_lo < 0) m_lo = k;
                end
            end
            if (m_lo >= 0) begin
                if (!m_valid || press_ack) begin
                    m_valid = 1'b1;
                    m_id    = 2'(m_lo);
                    if (m_nset > 1) m_oset = 1'b1;
                end else begin
                    m_oset = 1'b1;
                end
            end else if (press_ack) begin
                m_valid = 1'b0;
            end
            if (overrun_clr) m_ovr = 1'b0;
            else if (m_oset) m_ovr = 1'b1;

            m_s = hist.pop_front();
            hist.push_back(btn_raw);
            m_press = '0; m_release = '0;
            for (int k = 0; k < int'(NB); k++) begin
                if (m_s[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(DT)) begin
                        m_level[k] = m_s[k];
                        m_run[k]   = 0;
                        if (m_s[k]) m_press[k] = 1'b1;
                        else        m_release[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    end

    logic [15:0] obs_vec, exp_vec;
    assign obs_vec = {btn_level, btn_press, btn_release, press_valid, press_id, overrun};
    assign exp_vec = {m_level, m_press, m_release, m_valid, m_id, m_ovr};

    task automatic test_reset();
        RST = 1'b1; btn_raw = '0; press_ack = 1'b0; overrun_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_raw = 4'($urandom);
            @(negedge CLK);
            checks++;
            if (obs_vec !== 16'h0) begin
                errors++; $display("FAIL reset_outputs: got %h expected 0000", obs_vec);
            end
        end
        RST = 1'b0; btn_raw = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== 16'h0) begin
                errors++; $display("FAIL idle_after_reset: got %h expected 0000", obs_vec);
            end
        end
    endtask

    task automatic test_single_press();
        int n = 0;
        int at = -1;
        btn_raw[2] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL single_model: got %h expected %h", obs_vec, exp_vec);
            end
            if (btn_press[2]) begin n++; if (at < 0) at = i; end
        end
        checks++;
        if (n != 1 || at != 10) begin
            errors++; $display("FAIL press2_latency: got count %0d at %0d expected 1 at 10", n, at);
        end
        checks++;
        if (btn_level !== 4'b0100 || press_valid !== 1'b1 || press_id !== 2'd2) begin
            errors++; $display("FAIL press2_event: got level %b valid %b id %0d expected 0100 1 2",
                               btn_level, press_valid, press_id);
        end
        press_ack = 1'b1;
        @(negedge CLK);
        press_ack = 1'b0;
        checks++;
        if (press_valid !== 1'b0) begin
            errors++; $display("FAIL ack_clears: got %b expected 0", press_valid);
        end
        btn_raw[2] = 1'b0;
        n = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL release_model: got %h expected %h", obs_vec, exp_vec);
            end
            if (btn_release[2]) n++;
        end
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL release2_count: got %0d expected 1", n);
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        int at = -1;
        for (int k = 0; k < 5; k++) begin
            btn_raw[0] = (k % 2 == 0);
            for (int c = 0; c < ((k == 4) ? 14 : 3); c++) begin
                @(negedge CLK);
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++; $display("FAIL bounce_model: got %h expected %h", obs_vec, exp_vec);
                end
                if (btn_press[0]) begin np++; if (k == 4 && at < 0) at = c + 1; end
            end
        end
        checks++;
        if (np != 1 || at != 10) begin
            errors++; $display("FAIL bounce_press: got count %0d at %0d expected 1 at 10", np, at);
        end
        press_ack = 1'b1; btn_raw[0] = 1'b0;
        @(negedge CLK);
        press_ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bounce_tail: got %h expected %h", obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_overrun();
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL ovr_model_a: got %h expected %h", obs_vec, exp_vec);
            end
        end
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL ovr_model_b: got %h expected %h", obs_vec, exp_vec);
            end
        end
        checks++;
        if (press_valid !== 1'b1 || press_id !== 2'd1 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got valid %b id %0d ovr %b expected 1 1 1",
                               press_valid, press_id, overrun);
        end
        overrun_clr = 1'b1;
        @(negedge CLK);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clr: got %b expected 0", overrun);
        end
        press_ack = 1'b1; btn_raw = '0;
        @(negedge CLK);
        press_ack = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        btn_raw = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL simul_model: got %h expected %h", obs_vec, exp_vec);
            end
        end
        checks++;
        if (press_id !== 2'd1 || overrun !== 1'b1) begin
            errors++; $display("FAIL simul_press: got id %0d ovr %b expected 1 1", press_id, overrun);
        end
        overrun_clr = 1'b1; btn_raw = '0;
        @(negedge CLK);
        overrun_clr = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge CLK);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge CLK);
        checks++;
        if (btn_press[2] !== 1'b1 || press_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_pulse: got press %b valid %b expected 1 1", btn_press[2], press_valid);
        end
        press_ack = 1'b1;
        @(negedge CLK);
        press_ack = 1'b0;
        checks++;
        if (press_valid !== 1'b1 || press_id !== 2'd2 || overrun !== 1'b0) begin
            errors++; $display("FAIL ack_with_press: got valid %b id %0d ovr %b expected 1 2 0",
                               press_valid, press_id, overrun);
        end
        press_ack = 1'b1; btn_raw = '0;
        @(negedge CLK);
        press_ack = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge CLK);
    endtask

    task automatic test_reset_mid_debounce();
        int n = 0;
        int at = -1;
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== 16'h0 || obs_vec !== exp_vec) begin
                errors++; $display("FAIL reset_mid: got %h expected 0000", obs_vec);
            end
        end
        RST = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL redebounce_model: got %h expected %h", obs_vec, exp_vec);
            end
            if (btn_press[0]) begin n++; if (at < 0) at = i; end
        end
        checks++;
        if (n != 1 || at != 10) begin
            errors++; $display("FAIL redebounce: got count %0d at %0d expected 1 at 10", n, at);
        end
        press_ack = 1'b1; btn_raw = '0;
        @(negedge CLK);
        press_ack = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge CLK);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random_model cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            for (int k = 0; k < int'(NB); k++) begin
                if ($urandom_range(0, 11) == 0) btn_raw[k] = ~btn_raw[k];
            end
            press_ack   = ($urandom_range(0, 3) == 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
        end
        press_ack = 1'b0; overrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_overrun();
        test_back_to_back();
        test_reset_mid_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
